// File: rtl/dll_ctrl_pkg.sv
// Shared types and defaults for the DLL lock sequencer.
// State encoding, default geometry, and the mid-code helper.
package dll_ctrl_pkg;

  localparam int DEF_WIDTH      = 10;
  localparam int DEF_SETTLE_CYC = 8;
  localparam int DEF_VOTE_N     = 7;
  localparam int DEF_DRIFT_LIM  = 4;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SETTLE   = 3'd1,
    S_VOTE     = 3'd2,
    S_DECIDE   = 3'd3,
    S_T_SETTLE = 3'd4,
    S_T_VOTE   = 3'd5,
    S_T_DECIDE = 3'd6
  } state_t;

  function automatic int unsigned mid_code(
    input int unsigned w
  );
    return 32'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/pd_vote.sv
// Majority voter for the noisy phase detector.
// Counts VOTE_N samples; lag is the registered majority.
module pd_vote #(
  parameter int VOTE_N = 7
) (
  input  logic clk4,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic sample,
  output logic done,
  output logic lag
);

  localparam int CW = $clog2(VOTE_N + 1);
  localparam logic [CW-1:0] LAST = CW'(VOTE_N - 1);
  localparam logic [CW-1:0] HALF = CW'(VOTE_N / 2);

  logic [CW-1:0] n_cnt;
  logic [CW-1:0] lag_cnt;

  // sample counter and lag tally; clear wins over enable
  always_ff @(posedge clk4 or negedge rst_n) begin
    if (!rst_n) begin
      n_cnt   <= '0;
      lag_cnt <= '0;
    end else if (clr) begin
      n_cnt   <= '0;
      lag_cnt <= '0;
    end else if (en) begin
      n_cnt   <= n_cnt + CW'(1);
      lag_cnt <= lag_cnt + CW'(sample);
    end
  end

  // done flags the edge taking the final sample
  assign done = en && (n_cnt == LAST);
  assign lag  = lag_cnt > HALF;

endmodule

// File: rtl/dll_lock_ctrl.sv
// DLL delay-line acquisition and tracking sequencer.
// Binary search MSB-first, then +/-1 tracking with drift relock.
module dll_lock_ctrl
  import dll_ctrl_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int VOTE_N     = DEF_VOTE_N,
  parameter int DRIFT_LIM  = DEF_DRIFT_LIM
) (
  input  logic             clk4,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             pd_lag,
  output logic [WIDTH-1:0] dcw,
  output logic [3:0]       bit_idx,
  output logic             busy,
  output logic             locked,
  output logic             relock
);

  localparam int SW =
    (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SW-1:0] SET_LOAD =
    SW'(SETTLE_CYC - 1);
  localparam int DW = $clog2(DRIFT_LIM + 1);
  localparam logic [DW-1:0] DRIFT_TOP =
    DW'(DRIFT_LIM);
  localparam logic [WIDTH-1:0] MID =
    WIDTH'(mid_code(WIDTH));
  localparam logic [WIDTH-1:0] MAXC = '1;
  localparam logic [3:0] TOP_BIT = 4'(WIDTH - 1);

  state_t          state;
  logic [SW-1:0]   set_cnt;
  logic [DW-1:0]   drift;
  logic [DW-1:0]   drift_nx;
  logic            prev_lag;
  logic            settled;
  logic            v_clr;
  logic            v_en;
  logic            v_done;
  logic            v_lag;
  logic [WIDTH-1:0] bit_msk;
  logic [WIDTH-1:0] lo_msk;
  logic [WIDTH-1:0] acq_code;
  logic [WIDTH-1:0] trk_code;

  assign settled = (set_cnt == '0);
  assign v_clr   = settled &&
                   ((state == S_SETTLE) ||
                    (state == S_T_SETTLE));
  assign v_en    = (state == S_VOTE) ||
                   (state == S_T_VOTE);
  assign bit_msk = WIDTH'(1) << bit_idx;
  assign lo_msk  = bit_msk >> 1;

  pd_vote #(
    .VOTE_N (VOTE_N)
  ) u_vote (
    .clk4   (clk4),
    .rst_n  (rst_n),
    .clr    (v_clr),
    .en     (v_en),
    .sample (pd_lag),
    .done   (v_done),
    .lag    (v_lag)
  );

  // resolved search code, and the direction run length
  always_comb begin
    acq_code = dcw;
    if (v_lag) acq_code = dcw & ~bit_msk;
    drift_nx = (v_lag == prev_lag) ?
               drift + DW'(1) : DW'(1);
  end

  // saturating single-LSB tracking step
  always_comb begin
    trk_code = dcw;
    if (v_lag) begin
      if (dcw != '0) trk_code = dcw - WIDTH'(1);
    end else begin
      if (dcw != MAXC) trk_code = dcw + WIDTH'(1);
    end
  end

  // sequencer state, code registers and status flags
  always_ff @(posedge clk4 or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      dcw      <= MID;
      bit_idx  <= TOP_BIT;
      busy     <= 1'b0;
      locked   <= 1'b0;
      relock   <= 1'b0;
      set_cnt  <= '0;
      drift    <= '0;
      prev_lag <= 1'b0;
    end else begin
      relock <= 1'b0;
      if (abort) begin
        state  <= S_IDLE;
        busy   <= 1'b0;
        locked <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start) begin
              dcw     <= MID;
              bit_idx <= TOP_BIT;
              set_cnt <= SET_LOAD;
              busy    <= 1'b1;
              state   <= S_SETTLE;
            end
          end
          S_SETTLE: begin
            if (settled) state <= S_VOTE;
            else set_cnt <= set_cnt - SW'(1);
          end
          S_VOTE: begin
            if (v_done) state <= S_DECIDE;
          end
          S_DECIDE: begin
            set_cnt <= SET_LOAD;
            if (bit_idx != 4'd0) begin
              dcw     <= acq_code | lo_msk;
              bit_idx <= bit_idx - 4'd1;
              state   <= S_SETTLE;
            end else begin
              dcw    <= acq_code;
              locked <= 1'b1;
              drift  <= '0;
              state  <= S_T_SETTLE;
            end
          end
          S_T_SETTLE: begin
            if (settled) state <= S_T_VOTE;
            else set_cnt <= set_cnt - SW'(1);
          end
          S_T_VOTE: begin
            if (v_done) state <= S_T_DECIDE;
          end
          S_T_DECIDE: begin
            prev_lag <= v_lag;
            set_cnt  <= SET_LOAD;
            if (drift_nx == DRIFT_TOP) begin
              relock  <= 1'b1;
              locked  <= 1'b0;
              dcw     <= MID;
              bit_idx <= TOP_BIT;
              drift   <= '0;
              state   <= S_SETTLE;
            end else begin
              dcw   <= trk_code;
              drift <= drift_nx;
              state <= S_T_SETTLE;
            end
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dll_lock_ctrl.sv
// Scoreboard bench for dll_lock_ctrl.
// Stimulus queues expected outputs per cycle; a monitor compares.
module tb_dll_lock_ctrl;

  logic       clk4   = 1'b0;
  logic       rst_n  = 1'b0;
  logic       start  = 1'b0;
  logic       abort  = 1'b0;
  logic       pd_lag = 1'b0;
  logic [9:0] dcw;
  logic [3:0] bit_idx;
  logic       busy;
  logic       locked;
  logic       relock;

  dll_lock_ctrl dut (
    .clk4    (clk4),
    .rst_n   (rst_n),
    .start   (start),
    .abort   (abort),
    .pd_lag  (pd_lag),
    .dcw     (dcw),
    .bit_idx (bit_idx),
    .busy    (busy),
    .locked  (locked),
    .relock  (relock)
  );

  typedef struct {
    int         at;
    string      nm;
    logic [9:0] d;
    logic [3:0] b;
    logic       bs;
    logic       lk;
    logic       rl;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  int         pd_mode = 0;
  logic [9:0] target  = '0;
  logic       pd_val  = 1'b0;
  int         pbase   = 0;
  logic [6:0] pat     = '0;
  logic [2:0] pidx;

  initial forever #5 clk4 = ~clk4;

  initial forever begin
    @(posedge clk4);
    cyc++;
  end

  // phase-detector plant: target compare, constant, or vote pattern
  initial forever begin
    @(negedge clk4);
    if (pd_mode == 0) pd_lag = (dcw > target);
    else if (pd_mode == 1) pd_lag = pd_val;
    else if (cyc >= pbase && cyc < pbase + 7) begin
      pidx = 3'(cyc - pbase);
      pd_lag = pat[pidx];
    end else pd_lag = 1'b0;
  end

  // monitor: compare every expectation due at this cycle
  initial forever begin
    @(negedge clk4);
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      mon_e = sb.pop_front();
      n_cmp++;
      if (mon_e.at != cyc) begin
        n_bad++;
        $display("FAIL %s: check missed, due cycle %0d now %0d",
                 mon_e.nm, mon_e.at, cyc);
      end else if ({dcw, bit_idx, busy, locked, relock} !==
                   {mon_e.d, mon_e.b, mon_e.bs,
                    mon_e.lk, mon_e.rl}) begin
        n_bad++;
        $display({"FAIL %s @%0d: got dcw=%03h bi=%0d busy=%b",
                  " lk=%b rl=%b, want dcw=%03h bi=%0d busy=%b",
                  " lk=%b rl=%b"},
                 mon_e.nm, cyc, dcw, bit_idx, busy, locked,
                 relock, mon_e.d, mon_e.b, mon_e.bs,
                 mon_e.lk, mon_e.rl);
      end
    end
  end

  function automatic logic [9:0] exp_acq(
    input logic [9:0] t,
    input int         b
  );
    logic [9:0] r;
    r = (t >> b) << b;
    if (b > 0) r = r | (10'(1) << (b - 1));
    return r;
  endfunction

  function automatic void want(
    input int at, input string nm,
    input logic [9:0] d, input logic [3:0] b,
    input logic bs, input logic lk, input logic rl
  );
    sb.push_back('{at, nm, d, b, bs, lk, rl});
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk4);
      #1;
    end
  endtask

  task automatic tick_to(input int e);
    while (cyc < e) tick(1);
  endtask

  task automatic do_start(output int s);
    start = 1'b1;
    s = cyc + 1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic do_abort(output int e);
    abort = 1'b1;
    e = cyc + 1;
    tick(1);
    abort = 1'b0;
  endtask

  task automatic push_acq(input int s0, input logic [9:0] t);
    for (int k = 0; k < 10; k++) begin
      int b;
      b = 9 - k;
      want(s0 + 16 * (k + 1), $sformatf("acq%03h_b%0d", t, b),
           exp_acq(t, b), (b > 0) ? 4'(b - 1) : 4'd0,
           1'b1, (b == 0), 1'b0);
    end
  endtask

  initial begin
    int s0;
    int s1;
    int e;

    tick(3);
    rst_n = 1'b1;
    want(cyc, "rst", 10'h200, 4'd9, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 51; i += 10)
      want(cyc + i, "rst_idle", 10'h200, 4'd9,
           1'b0, 1'b0, 1'b0);
    tick(55);

    // acquisition to 0x2A5, then alternating tracking
    target = 10'h2A5;
    pd_mode = 0;
    do_start(s0);
    want(s0, "start", 10'h200, 4'd9, 1'b1, 1'b0, 1'b0);
    push_acq(s0, 10'h2A5);
    for (int j = 1; j <= 20; j++)
      want(s0 + 160 + 16 * j, $sformatf("alt%0d", j),
           (j % 2 == 1) ? 10'h2A6 : 10'h2A5, 4'd0,
           1'b1, 1'b1, 1'b0);
    tick_to(s0 + 29);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick_to(s0 + 160 + 16 * 20 + 3);
    do_abort(e);
    want(e, "abort_trk", 10'h2A5, 4'd0, 1'b0, 1'b0, 1'b0);
    tick(3);

    // constant lag from lock drives a relock
    do_start(s0);
    want(s0 + 160, "lock_b", 10'h2A5, 4'd0,
         1'b1, 1'b1, 1'b0);
    tick_to(s0 + 161);
    pd_mode = 1;
    pd_val = 1'b1;
    for (int j = 1; j <= 3; j++)
      want(s0 + 160 + 16 * j, $sformatf("lag%0d", j),
           10'h2A5 - 10'(j), 4'd0, 1'b1, 1'b1, 1'b0);
    want(s0 + 224, "relock", 10'h200, 4'd9,
         1'b1, 1'b0, 1'b1);
    want(s0 + 225, "relock_end", 10'h200, 4'd9,
         1'b1, 1'b0, 1'b0);
    tick_to(s0 + 230);
    do_abort(e);
    tick(3);

    // lock at the bottom rail, then saturated lag steps
    target = 10'h000;
    pd_mode = 0;
    do_start(s0);
    push_acq(s0, 10'h000);
    tick_to(s0 + 161);
    pd_mode = 1;
    pd_val = 1'b1;
    for (int j = 1; j <= 3; j++)
      want(s0 + 160 + 16 * j, $sformatf("rail%0d", j),
           10'h000, 4'd0, 1'b1, 1'b1, 1'b0);
    want(s0 + 224, "rail_relock", 10'h200, 4'd9,
         1'b1, 1'b0, 1'b1);
    tick_to(s0 + 228);
    do_abort(e);
    tick(3);

    // lock at the top rail
    target = 10'h3FF;
    pd_mode = 0;
    do_start(s0);
    push_acq(s0, 10'h3FF);
    tick_to(s0 + 162);
    do_abort(e);
    tick(3);

    // majority vote: 3 of 7 lag -> lead, 4 of 7 -> lag
    pd_mode = 2;
    pat = 7'b0101010;
    pbase = cyc + 1 + 8;
    do_start(s0);
    want(s0 + 16, "vote3", 10'h300, 4'd8, 1'b1, 1'b0, 1'b0);
    tick_to(s0 + 18);
    do_abort(e);
    tick(3);
    pat = 7'b1010101;
    pbase = cyc + 1 + 8;
    do_start(s0);
    want(s0 + 16, "vote4", 10'h100, 4'd8, 1'b1, 1'b0, 1'b0);
    tick_to(s0 + 18);
    do_abort(e);
    tick(3);

    // abort during bit-5 settle, start+abort, restart
    target = 10'h2A5;
    pd_mode = 0;
    do_start(s0);
    for (int k = 0; k < 4; k++)
      want(s0 + 16 * (k + 1), $sformatf("pre_b%0d", 9 - k),
           exp_acq(10'h2A5, 9 - k), 4'(8 - k),
           1'b1, 1'b0, 1'b0);
    tick_to(s0 + 65);
    do_abort(e);
    want(e, "abort", 10'h2A0, 4'd5, 1'b0, 1'b0, 1'b0);
    tick_to(s0 + 69);
    start = 1'b1;
    abort = 1'b1;
    tick(1);
    start = 1'b0;
    abort = 1'b0;
    want(s0 + 70, "start_abort", 10'h2A0, 4'd5,
         1'b0, 1'b0, 1'b0);
    want(s0 + 75, "still_idle", 10'h2A0, 4'd5,
         1'b0, 1'b0, 1'b0);
    tick_to(s0 + 79);
    do_start(s1);
    want(s1, "restart", 10'h200, 4'd9, 1'b1, 1'b0, 1'b0);
    want(s1 + 160, "relock_acq", 10'h2A5, 4'd0,
         1'b1, 1'b1, 1'b0);
    tick_to(s1 + 161);
    do_abort(e);
    tick(3);

    // asynchronous reset mid-acquisition
    target = 10'h0F0;
    do_start(s0);
    tick_to(s0 + 40);
    want(cyc, "async_rst", 10'h200, 4'd9, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    want(cyc + 2, "post_rst", 10'h200, 4'd9,
         1'b0, 1'b0, 1'b0);
    tick(6);

    if (sb.size() != 0) begin
      n_cmp += sb.size();
      n_bad += sb.size();
      $display("FAIL leftover: %0d checks never reached",
               sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
